// File: rtl/rv32_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32_bus_arbiter
// Purpose  : Shares one external memory bus between the fetch and memory-stage
//            ports. Holds the grant until completion; a watchdog turns a hung
//            transfer into a fault. Optional macro: RV32_ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_read_in,
  input  logic [31:0] instr_address_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  output logic        instr_fault_out,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [31:0] data_address_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic        data_fault_out,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic [15:0] counter, counter_next;
  logic        data_req;
  logic        grant_data;
  logic        own_instr, own_data;
  logic        done, fault;

  assign data_req = data_read_in | data_write_in;

`ifdef RV32_ARB_ROUND_ROBIN_EN
  // last_grant_data = 0 means the instruction port completed most recently.
  logic last_grant_data;

  assign grant_data = data_req & (~instr_read_in | ~last_grant_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_data <= 1'b0;
    end else if (done) begin
      last_grant_data <= own_data;
    end
  end
`else
  assign grant_data = data_req;
`endif

  always_comb begin
    state_next   = state;
    counter_next = counter;
    own_instr    = 1'b0;
    own_data     = 1'b0;
    done         = 1'b0;
    fault        = 1'b0;
    case (state)
      IDLE: begin
        own_data  = grant_data;
        own_instr = ~grant_data & instr_read_in;
        if (own_instr | own_data) begin
          if (ready_in) begin
            done = 1'b1;
          end else begin
            state_next   = own_data ? DATA : INSTR;
            counter_next = 16'd1;
          end
        end
      end
      INSTR, DATA: begin
        own_instr = (state == INSTR) & instr_read_in;
        own_data  = (state == DATA) & data_req;
        if (!(own_instr | own_data)) begin
          // Requester withdrew: silent abort, no completion pulse.
          state_next   = IDLE;
          counter_next = 16'd0;
        end else if (ready_in) begin
          done = 1'b1;
        end else if (counter == TIMEOUT_LIMIT) begin
          done  = 1'b1;
          fault = 1'b1;
        end else if (counter != 16'hFFFF) begin
          counter_next = counter + 16'd1;
        end
      end
      default: begin
        state_next   = IDLE;
        counter_next = 16'd0;
      end
    endcase
    if (done) begin
      state_next   = IDLE;
      counter_next = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= 16'd0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  always_comb begin
    address_out          = 32'd0;
    read_out             = 1'b0;
    write_out            = 1'b0;
    write_mask_out       = 4'd0;
    write_value_out      = 32'd0;
    instr_read_value_out = 32'd0;
    instr_ready_out      = 1'b0;
    instr_fault_out      = 1'b0;
    data_read_value_out  = 32'd0;
    data_ready_out       = 1'b0;
    data_fault_out       = 1'b0;
    if (!reset) begin
      if (own_instr) begin
        address_out = instr_address_in;
        read_out    = ~fault;
      end else if (own_data) begin
        address_out     = data_address_in;
        read_out        = data_read_in & ~fault;
        write_out       = data_write_in & ~fault;
        write_mask_out  = data_write_mask_in;
        write_value_out = data_write_value_in;
      end
      instr_ready_out      = own_instr & done;
      instr_fault_out      = own_instr & fault;
      instr_read_value_out = (own_instr & fault) ? 32'd0 : read_value_in;
      data_ready_out       = own_data & done;
      data_fault_out       = own_data & fault;
      data_read_value_out  = (own_data & fault) ? 32'd0 : read_value_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_bus_arbiter
// Purpose  : Directed self-checking bench for rv32_bus_arbiter (TIMEOUT 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_read_in;
  logic [31:0] instr_address_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out, instr_fault_out;
  logic        data_read_in, data_write_in;
  logic [31:0] data_address_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out, data_fault_out;
  logic [31:0] address_out;
  logic        read_out, write_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;

  int n_assert = 0;
  int n_fail   = 0;

  rv32_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instr_read_in       (instr_read_in),
    .instr_address_in    (instr_address_in),
    .instr_read_value_out(instr_read_value_out),
    .instr_ready_out     (instr_ready_out),
    .instr_fault_out     (instr_fault_out),
    .data_read_in        (data_read_in),
    .data_write_in       (data_write_in),
    .data_address_in     (data_address_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_write_value_in (data_write_value_in),
    .data_read_value_out (data_read_value_out),
    .data_ready_out      (data_ready_out),
    .data_fault_out      (data_fault_out),
    .address_out         (address_out),
    .read_out            (read_out),
    .write_out           (write_out),
    .write_mask_out      (write_mask_out),
    .write_value_out     (write_value_out),
    .read_value_in       (read_value_in),
    .ready_in            (ready_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_read_in       = 1'b0;
    instr_address_in    = 32'd0;
    data_read_in        = 1'b0;
    data_write_in       = 1'b0;
    data_address_in     = 32'd0;
    data_write_mask_in  = 4'd0;
    data_write_value_in = 32'd0;
    read_value_in       = 32'd0;
    ready_in            = 1'b0;
  endtask

  initial begin
    clear_inputs();
    // Reset with live requests and ready: everything held quiet.
    reset = 1'b1; instr_read_in = 1'b1; instr_address_in = 32'h44; ready_in = 1'b1;
    #2;
    chk("rst_instr_ready", {31'd0, instr_ready_out}, 32'd0);
    chk("rst_read_out",    {31'd0, read_out}, 32'd0);
    chk("rst_address",     address_out, 32'd0);
    step(); step();
    reset = 1'b0;

    // Zero-latency instruction fetch.
    instr_address_in = 32'h100; read_value_in = 32'h1234_5678;
    #2;
    chk("zl_instr_ready", {31'd0, instr_ready_out}, 32'd1);
    chk("zl_read_out",    {31'd0, read_out}, 32'd1);
    chk("zl_address",     address_out, 32'h100);
    chk("zl_rdata",       instr_read_value_out, 32'h1234_5678);
    chk("zl_fault",       {31'd0, instr_fault_out}, 32'd0);
    chk("zl_data_ready",  {31'd0, data_ready_out}, 32'd0);
    step();
    clear_inputs();
    #2;
    chk("idle_read_out", {31'd0, read_out}, 32'd0);
    step();

    // Data write held 3 cycles; instr request joins from cycle 1 and must wait.
    data_write_in = 1'b1; data_address_in = 32'h200;
    data_write_mask_in = 4'hF; data_write_value_in = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("dw_write_out", {31'd0, write_out}, 32'd1);
      chk("dw_address",   address_out, 32'h200);
      chk("dw_mask",      {28'd0, write_mask_out}, 32'hF);
      chk("dw_value",     write_value_out, 32'hDEAD_BEEF);
      chk("dw_ready",     {30'd0, data_ready_out, instr_ready_out}, 32'd0);
      step();
      instr_read_in = 1'b1; instr_address_in = 32'h999;
    end
    ready_in = 1'b1;
    #2;
    chk("dw_done",       {30'd0, data_ready_out, instr_ready_out}, 32'd2);
    chk("dw_done_addr",  address_out, 32'h200);
    step();
    data_write_in = 1'b0;
    #2;
    chk("b2b_instr_ready", {31'd0, instr_ready_out}, 32'd1);
    chk("b2b_address",     address_out, 32'h999);
    step();

    // Contention: data beats instr, instr served the very next cycle.
    clear_inputs();
    instr_read_in = 1'b1; instr_address_in = 32'h0;
    data_read_in = 1'b1; data_address_in = 32'h40;
    read_value_in = 32'hA5A5_A5A5; ready_in = 1'b1;
    #2;
    chk("ct_first",     {30'd0, data_ready_out, instr_ready_out}, 32'd2);
    chk("ct_first_adr", address_out, 32'h40);
    chk("ct_rdata",     data_read_value_out, 32'hA5A5_A5A5);
    step();
    data_read_in = 1'b0;
    #2;
    chk("ct_second",     {30'd0, data_ready_out, instr_ready_out}, 32'd1);
    chk("ct_second_adr", address_out, 32'h0);
    step();

    // Watchdog: grant, then 4 held cycles, fault on the 4th.
    clear_inputs();
    instr_read_in = 1'b1; instr_address_in = 32'h300; read_value_in = 32'hFFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("to_wait_read", {31'd0, read_out}, 32'd1);
      chk("to_wait_rdy",  {31'd0, instr_ready_out}, 32'd0);
      step();
    end
    #2;
    chk("to_ready", {31'd0, instr_ready_out}, 32'd1);
    chk("to_fault", {31'd0, instr_fault_out}, 32'd1);
    chk("to_rdata", instr_read_value_out, 32'd0);
    chk("to_read",  {31'd0, read_out}, 32'd0);
    step();
    ready_in = 1'b1;
    #2;
    chk("to_after_ready", {31'd0, instr_ready_out}, 32'd1);
    chk("to_after_fault", {31'd0, instr_fault_out}, 32'd0);
    step();

    // Reset during a held data write.
    clear_inputs();
    data_write_in = 1'b1; data_address_in = 32'h500;
    step(); step();
    reset = 1'b1;
    #2;
    chk("rm_write_out",  {31'd0, write_out}, 32'd0);
    chk("rm_data_ready", {31'd0, data_ready_out}, 32'd0);
    step();
    reset = 1'b0; data_write_in = 1'b0;
    instr_read_in = 1'b1; instr_address_in = 32'h504; ready_in = 1'b1;
    #2;
    chk("rm_write_after", {31'd0, write_out}, 32'd0);
    chk("rm_instr_ready", {31'd0, instr_ready_out}, 32'd1);
    chk("rm_instr_addr",  address_out, 32'h504);
    step();

    // Owner withdraws mid-hold: silent abort, IDLE next cycle.
    clear_inputs();
    data_read_in = 1'b1; data_address_in = 32'h600;
    step();
    #2;
    chk("ab_held_read", {31'd0, read_out}, 32'd1);
    step();
    data_read_in = 1'b0;
    #2;
    chk("ab_strobe", {30'd0, read_out, write_out}, 32'd0);
    chk("ab_pulses", {28'd0, data_ready_out, data_fault_out, instr_ready_out, instr_fault_out}, 32'd0);
    step();
    instr_read_in = 1'b1; instr_address_in = 32'h700;
    #2;
    chk("ab_regrant_addr", address_out, 32'h700);
    chk("ab_regrant_read", {31'd0, read_out}, 32'd1);
    step();
    ready_in = 1'b1;
    #2;
    chk("ab_regrant_done", {31'd0, instr_ready_out}, 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32_bus_arbiter.md
Name: rv32_bus_arbiter

Overview:
- Shares the core's single external memory bus between the fetch-stage instruction port and the memory-stage data port.
- Arbitrates contention and holds the grant until the bus completes the transfer.
- Returns read data and ready/fault to the owning requester.
- A watchdog converts a hung bus transfer into a fault, so the hazard unit never stalls forever.

Parameters:
TIMEOUT_CYCLES, 255, held-state cycles without ready_in before the transfer is aborted with a fault (range 1..65535).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
instr_read_in  in  1  fetch requests a word read
instr_address_in  in  32  fetch address
instr_read_value_out  out  32  fetched word, valid when instr_ready_out
instr_ready_out  out  1  fetch transfer complete (one-cycle pulse)
instr_fault_out  out  1  fetch transfer timed out (qualifies instr_ready_out)
data_read_in  in  1  memory stage read request
data_write_in  in  1  memory stage write request
data_address_in  in  32  data address
data_write_mask_in  in  4  byte enables
data_write_value_in  in  32  store data
data_read_value_out  out  32  load data, valid when data_ready_out
data_ready_out  out  1  data transfer complete (one-cycle pulse)
data_fault_out  out  1  data transfer timed out (qualifies data_ready_out)
address_out  out  32  bus address
read_out  out  1  bus read strobe
write_out  out  1  bus write strobe
write_mask_out  out  4  bus byte enables
write_value_out  out  32  bus write data
read_value_in  in  32  bus read data
ready_in  in  1  bus completes current transfer this cycle

Behaviour:
- Reset is a synchronous clk clock domain reset, active-high, named reset.
- States: IDLE, INSTR, DATA. Reset forces IDLE, timeout counter 0, last_grant = INSTR.
- While reset is high, all ready/fault outputs and read_out/write_out are 0. Other outputs are don't-care but are driven to 0.
- Bus outputs are combinational from the current owner:
  - IDLE: owner = arbitration winner.
  - INSTR or DATA: owner = held requester.
  - Non-owner request signals never reach the bus.
- Arbitration in IDLE: data request (data_read_in | data_write_in) beats instr_read_in.
- Instr owner drives: address_out = instr_address_in, read_out = 1, write_out = 0, write_mask_out = 0, write_value_out = 0.
- Data owner drives data_* fields straight through.
- Zero-latency completion: in IDLE, if a request is granted and ready_in = 1 in the same cycle, the owner's ready pulses that cycle and the state stays IDLE.
- If granted in IDLE with ready_in = 0, the state moves to INSTR or DATA and the counter loads 1.
- Held state with ready_in = 1: owner ready = 1, read_value_out = read_value_in, next state IDLE, counter cleared.
- Non-owner ready/fault are always 0. read_value_out of both ports equals read_value_in regardless of owner; consumers qualify it with ready.
- Held state with ready_in = 0: counter increments.
  - When counter == TIMEOUT_CYCLES: owner ready = 1, fault = 1, read_value_out = 0, bus strobes deasserted that cycle, next state IDLE.
- Requesters hold their request stable until ready.
  - If the owner drops its request while held, bus strobes drop the same cycle and the state returns to IDLE next cycle with no ready pulse (abort).
- A late ready_in arriving after a timeout or abort, while IDLE, completes whatever is then granted. The bus must not do this; it is documented as a bus protocol violation.
- data_read_in and data_write_in both high is illegal. Both strobes are passed through.
- Counter width is 16 bits. It saturates, never wraps.
- A new grant in the cycle after completion is allowed: back-to-back transfers get 1 transfer per cycle when ready_in stays high.

Optional Feature:
- Macro RV32_ARB_ROUND_ROBIN_EN.
- Defined:
  - last_grant register updates on every completion (ready or fault).
  - On simultaneous instr and data requests in IDLE, the requester not equal to last_grant wins.
- Undefined: fixed data-over-instr priority and last_grant is unused.

Test Plan:
- Instr only, address 0x100, ready_in high same cycle → instr_ready_out pulse cycle 0, read_out = 1, address_out = 0x100, state stays IDLE.
- Data write 0x200, mask 0xF, value 0xDEADBEEF, ready_in after 3 cycles → state DATA, bus fields stable for 4 cycles, data_ready_out pulses on the 4th cycle, no instr_ready_out.
- Simultaneous instr 0x0 and data read 0x40, ready_in always high → data served first, instr next cycle. With RV32_ARB_ROUND_ROBIN_EN, a repeat of the contention serves instr first.
- TIMEOUT_CYCLES = 4, instr read, ready_in never high → instr_ready_out and instr_fault_out pulse together 4 held cycles after grant, instr_read_value_out = 0, state IDLE.
- Reset asserted mid-DATA hold (cycle 2) → next cycle state IDLE, write_out = 0, counter 0, no data_ready_out. A subsequent instr request is granted normally.
- Data owner drops data_read_in mid-hold → strobes drop that cycle, IDLE next cycle, no ready/fault pulse.
